osc_freq_meter: RTL and testbench

Digital frequency meter for the on-chip relaxation oscillators. It is the parametrised successor to the single-oscillator stub.
- Takes NUM_CH free-running, asynchronous oscillator outputs.
- Synchronises them into the clk domain and counts rising edges of one selected channel over a programmable gate window of clk cycles.
- Publishes the count, channel and overflow status with a done pulse.
- Sits between the analog osc macros and the tile's digital I/O, so oscillator frequency is readable without a scope.

---
 rtl/osc_meter_pkg.sv | 24 ++
 rtl/osc_sync.sv | 27 ++
 rtl/osc_freq_meter.sv | 181 ++++++++++++++++++
 tb/tb_osc_freq_meter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_meter_pkg.sv
// Shared types and constants for the oscillator frequency meter.
// Holds the FSM state encoding and the channel-select width helper.
package osc_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_GATE,
      ST_DONE
   } state_t;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_GATE_W      = 16;
   localparam int DEF_SYNC_STAGES = 2;

   // Width of a channel index, never narrower than one bit.
   function automatic int chsel_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/osc_sync.sv
// Multi-flop synchroniser for one asynchronous oscillator bit.
// Runs continuously; cleared only by reset.
module osc_sync
   import osc_meter_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_ff;

   // Shift the raw bit through the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ff <= '0;
      end else begin
         r_ff <= {r_ff[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/osc_freq_meter.sv
// Gated rising-edge counter for NUM_CH asynchronous oscillators.
// One channel is measured per window; results publish with a done pulse.
module osc_freq_meter
   import osc_meter_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int GATE_W      = DEF_GATE_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   input  logic [NUM_CH-1:0]            osc_in,
   input  logic [chsel_w(NUM_CH)-1:0]   ch_sel,
   input  logic [GATE_W-1:0]            gate_len,
   input  logic                         start,
   input  logic                         cont,
   output logic                         busy,
   output logic                         done,
   output logic [CNT_W-1:0]             result_cnt,
   output logic [chsel_w(NUM_CH)-1:0]   result_ch,
   output logic                         result_ovf
);

   localparam int CH_W = chsel_w(NUM_CH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic              w_done;

   logic [NUM_CH-1:0] w_sync;
   logic              w_sel;
   logic              w_rise;
   logic              r_prev;

   logic [CH_W-1:0]   r_ch;
   logic [GATE_W-1:0] r_gate_len;
   logic              r_cont;
   logic [GATE_W-1:0] r_gate_cnt;
   logic [CNT_W-1:0]  r_edge_cnt;
   logic              r_ovf;

   logic [CNT_W-1:0]  r_res_cnt;
   logic [CH_W-1:0]   r_res_ch;
   logic              r_res_ovf;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_sync
         osc_sync #(
            .STAGES (SYNC_STAGES)
         ) u_sync (
            .clk (clk),
            .rst (rst),
            .i_d (osc_in[g]),
            .o_q (w_sync[g])
         );
      end
   endgenerate

   // Select the latched channel; out-of-range indices read as 0.
   always_comb begin
      w_sel = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_ch == CH_W'(i)) begin
            w_sel = w_sync[i];
         end
      end
   end

   assign w_rise = w_sel & ~r_prev;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, start acceptance and done pulse; ena low forces IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      if (!ena) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start && (gate_len != '0)) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_ARM;
               end
            end
            ST_ARM: begin
               w_state_nxt = ST_GATE;
            end
            ST_GATE: begin
               if (r_gate_cnt == GATE_W'(1)) begin
                  w_state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               w_done      = 1'b1;
               w_state_nxt = r_cont ? ST_ARM : ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Edge history tracks the selected channel every cycle, so the
   // ARM cycle primes it with the newly latched channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_sel;
      end
   end

   // Settings latch, gate and edge counters, result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch       <= '0;
         r_gate_len <= '0;
         r_cont     <= 1'b0;
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_ovf      <= 1'b0;
         r_res_cnt  <= '0;
         r_res_ch   <= '0;
         r_res_ovf  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_ch       <= ch_sel;
            r_gate_len <= gate_len;
            r_cont     <= cont;
         end
         unique case (r_state)
            ST_ARM: begin
               r_edge_cnt <= '0;
               r_ovf      <= 1'b0;
               r_gate_cnt <= r_gate_len;
            end
            ST_GATE: begin
               r_gate_cnt <= r_gate_cnt - GATE_W'(1);
               if (w_rise) begin
                  if (r_edge_cnt == '1) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (w_done) begin
                  r_res_cnt <= r_edge_cnt;
                  r_res_ch  <= r_ch;
                  r_res_ovf <= r_ovf;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy       = (r_state != ST_IDLE);
   assign done       = w_done;
   assign result_cnt = r_res_cnt;
   assign result_ch  = r_res_ch;
   assign result_ovf = r_res_ovf;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: timing, counts, overflow,
// continuous mode, ignored starts, abort and async reset.
module tb_osc_freq_meter;

   logic        clk;
   logic        rst;
   logic        ena;
   logic [3:0]  osc_in;
   logic [1:0]  ch_sel;
   logic [15:0] gate_len;
   logic        start;
   logic        cont;

   logic        busy;
   logic        done;
   logic [15:0] result_cnt;
   logic [1:0]  result_ch;
   logic        result_ovf;

   logic        o_busy;
   logic        o_done;
   logic [3:0]  o_cnt;
   logic [1:0]  o_ch;
   logic        o_ovf;

   int n_cmp;
   int n_bad;

   int         half [4] = '{0, 5, 5, 2};
   int         tick [4] = '{default: 0};
   logic [3:0] hold = 4'b0001;

   osc_freq_meter u_dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .osc_in     (osc_in),
      .ch_sel     (ch_sel),
      .gate_len   (gate_len),
      .start      (start),
      .cont       (cont),
      .busy       (busy),
      .done       (done),
      .result_cnt (result_cnt),
      .result_ch  (result_ch),
      .result_ovf (result_ovf)
   );

   osc_freq_meter #(
      .CNT_W (4)
   ) u_ovf (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .osc_in     (osc_in),
      .ch_sel     (ch_sel),
      .gate_len   (gate_len),
      .start      (start),
      .cont       (cont),
      .busy       (o_busy),
      .done       (o_done),
      .result_cnt (o_cnt),
      .result_ch  (o_ch),
      .result_ovf (o_ovf)
   );

   // 10 ns clock, rising edges at 5 + 10k.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oscillators change at 2 + 10k, never on a clock edge.
   initial begin
      osc_in = '0;
      #2;
      forever begin
         for (int c = 0; c < 4; c++) begin
            if (half[c] == 0) begin
               osc_in[c] = hold[c];
            end else begin
               tick[c]++;
               if (tick[c] >= half[c]) begin
                  tick[c]   = 0;
                  osc_in[c] = ~osc_in[c];
               end
            end
         end
         #10;
      end
   end

   task automatic check(input string tag,
                        input int    obs,
                        input int    exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input int   ch,
                     input int   gl,
                     input logic c);
      ch_sel   = 2'(ch);
      gate_len = 16'(gl);
      cont     = c;
      start    = 1'b1;
   endtask

   task automatic wait_done(input  int n0,
                            input  int max,
                            output int n);
      n = n0;
      while (n < max) begin
         step();
         n++;
         if (n == 1) start = 1'b0;
         if (done) break;
      end
   endtask

   function automatic int in_rng(input int v,
                                 input int lo,
                                 input int hi);
      return (v >= lo && v <= hi) ? 1 : 0;
   endfunction

   initial begin
      int n;
      int pulses;
      n_cmp    = 0;
      n_bad    = 0;
      rst      = 1'b1;
      ena      = 1'b1;
      start    = 1'b0;
      cont     = 1'b0;
      ch_sel   = '0;
      gate_len = '0;

      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", result_cnt, 0);
      check("rst_ch", result_ch, 0);
      check("rst_ovf", result_ovf, 0);
      rst = 1'b0;
      step();
      check("post_rst_busy", busy, 0);

      // Basic measurement on channel 1.
      go(1, 100, 1'b0);
      wait_done(0, 300, n);
      check("basic_lat", n, 102);
      step();
      check("basic_cnt", in_rng(result_cnt, 9, 11), 1);
      check("basic_ch", result_ch, 1);
      check("basic_ovf", result_ovf, 0);
      check("basic_idle", busy, 0);

      // Overflow on channel 3 (period 4 clk, ~50 edges).
      go(3, 200, 1'b0);
      wait_done(0, 400, n);
      check("ovf_lat", n, 202);
      check("ovf_done4", o_done, 1);
      step();
      check("ovf_cnt4", o_cnt, 15);
      check("ovf_flag4", o_ovf, 1);
      check("ovf_ch4", o_ch, 3);
      check("wide_cnt", in_rng(result_cnt, 49, 51), 1);
      check("wide_ovf", result_ovf, 0);

      // gate_len of zero is ignored.
      go(1, 0, 1'b0);
      step();
      start = 1'b0;
      check("g0_busy", busy, 0);
      step();
      check("g0_busy2", busy, 0);

      // Shortest window.
      go(1, 1, 1'b0);
      wait_done(0, 20, n);
      check("g1_lat", n, 3);
      step();
      check("g1_idle", busy, 0);

      // start during GATE must not alter timing or channel.
      go(1, 20, 1'b0);
      wait_done(0, 5, n);
      ch_sel   = 2'd3;
      gate_len = 16'd3;
      start    = 1'b1;
      step();
      start    = 1'b0;
      wait_done(6, 60, n);
      check("gstart_lat", n, 22);
      step();
      check("gstart_ch", result_ch, 1);

      // Continuous on channel 2; channel 0 held high.
      go(2, 50, 1'b1);
      wait_done(0, 200, n);
      check("cont_lat1", n, 52);
      step();
      check("cont_cnt1", in_rng(result_cnt, 4, 6), 1);
      check("cont_ch1", result_ch, 2);
      check("cont_busy", busy, 1);
      ch_sel   = 2'd0;
      gate_len = 16'd7;
      cont     = 1'b0;
      start    = 1'b1;
      step();
      start    = 1'b0;
      wait_done(2, 200, n);
      check("cont_period", n, 52);
      step();
      check("cont_cnt2", in_rng(result_cnt, 4, 6), 1);
      check("cont_ch2", result_ch, 2);
      ena = 1'b0;
      step();
      check("cont_stop", busy, 0);
      ena = 1'b1;

      // Abort mid-window keeps previous results.
      go(1, 100, 1'b0);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (i == 0) start = 1'b0;
         if (done) pulses++;
      end
      ena = 1'b0;
      step();
      check("abort_busy", busy, 0);
      for (int i = 0; i < 80; i++) begin
         step();
         if (done) pulses++;
      end
      ena = 1'b1;
      check("abort_pulses", pulses, 0);
      check("abort_ch", result_ch, 2);
      check("abort_cnt", in_rng(result_cnt, 4, 6), 1);
      check("abort_ovf", result_ovf, 0);

      // Asynchronous reset mid-window, between clock edges.
      go(1, 100, 1'b0);
      step();
      start = 1'b0;
      repeat (20) step();
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_cnt", result_cnt, 0);
      check("arst_ch", result_ch, 0);
      check("arst_ovf", result_ovf, 0);
      check("arst_ovf4", o_ovf, 0);
      step();
      rst = 1'b0;
      step();
      check("arst_rel", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
